rate_generation: RTL and testbench
==================================

# rate_generation

Upstream stage of the clks_alot event path: divides the system clock into the io clock and produces the per-half-period timing strobes consumed by `event_generation`. A programmable counter sets the half-period length, and a second compare point marks the quarter point. A three-state controller starts the clock cleanly, stops it only at its idle level, and applies rate changes only on half-period boundaries.

## Interface
- `COUNTER_WIDTH`, default 16: width of the half-period and quarter-point targets and of the internal counter.
- `sys_dom_i` input, `common_p::clk_dom`: clock/reset bundle. One clock; reset is asynchronous and active-high.
- `clock_enable_i` input, 1: request io clock to run; level-sensitive.
- `idle_high_i` input, 1: idle (CPOL) level of `io_clk_o`; sampled only in IDLE.
- `half_rate_target_i` input, COUNTER_WIDTH: half period = target+1 sys cycles.
- `quarter_rate_target_i` input, COUNTER_WIDTH: count value at which the quarter strobe fires.
- `rate_update_i` input, 1: one-cycle request to capture both targets.
- `clock_active_o` output, 1: high in any state other than IDLE; drives `clock_active_i` downstream.
- `io_clk_o` output, 1: generated io clock.
- `half_rate_elapsed_o` output, 1: one-cycle strobe in the last cycle of a half period, while `io_clk_o` still holds the old level.
- `quarter_rate_elapsed_o` output, 1: one-cycle strobe when the counter equals the quarter target.
- `burst_len_i` input, 16, and `burst_done_o` output, 1: present only under `CLKS_ALOT_BURST_EN`.

## Operation
- Reset values:
  - state IDLE, counter 0, latched idle level 0.
  - `io_clk_o` = 0 and all strobes, `clock_active_o` and `burst_done_o` = 0.
  - active and pending targets = 0.
- Counter:
  - runs 0..half_target.
  - Boundary cycle: counter == half_target. Next cycle the counter returns to 0 and `io_clk_o` toggles, unless suppressed by DRAIN.
- Quarter strobe:
  - asserted when counter == quarter_target, in RUN or DRAIN.
  - never asserted if quarter_target >= half_target.
- States:
  - IDLE: `io_clk_o` = latched idle level, counter held at 0.
    - `clock_enable_i` = 1 → RUN. Count starts at 0 the next cycle.
    - The first half period holds the idle level.
  - RUN: free-running toggle.
    - `clock_enable_i` = 0 → DRAIN; the counter continues.
  - DRAIN, at the boundary cycle:
    - If `io_clk_o` != idle level: assert the strobe, toggle, → IDLE.
    - If `io_clk_o` == idle level: suppress `half_rate_elapsed_o`, do not toggle, → IDLE.
    - `clock_enable_i` = 1 in DRAIN → RUN with no counter reset.
- Rate update:
  - `rate_update_i` captures both targets into pending registers.
  - Pending values load into the active targets at the next boundary, or immediately if in IDLE.
  - If the update coincides with a boundary, the new targets govern the half period starting next cycle (bypass).
- `idle_high_i` is latched on every IDLE cycle; changes while active are ignored until IDLE.

## Timing
- Registered outputs; strobes align with the counter register value in the same cycle.
- Enable → `clock_active_o` high: 1 cycle.
- Target 3 gives a 4-cycle half period and an 8-cycle io period.
- Target 0 gives a 2-cycle period; `half_rate_elapsed_o` is high every cycle and quarter never fires.
- Reset mid-operation forces the reset values asynchronously; no strobe is emitted on reset release.

## Configuration
- `CLKS_ALOT_BURST_EN` defined:
  - `burst_len_i` is sampled on the IDLE→RUN transition.
  - Each completed full io cycle (return to the idle level) decrements the count.
  - At zero the block → IDLE after that boundary and pulses `burst_done_o` for 1 cycle, coincident with entry to IDLE.
  - `burst_len_i` = 0 means continuous.
  - Deasserting `clock_enable_i` still drains early, with no done pulse.
- Undefined: the burst ports and logic are absent; the clock runs until enable is deasserted.

## Structure
- `clks_alot_p` additions:
  - `rate_gen_state_e` (IDLE, RUN, DRAIN).
  - `rate_cfg_s` {half_target, quarter_target}.
  - `RATE_COUNTER_WIDTH_DEFAULT`.
- One sub-module, `half_period_counter`: counter plus target compare. It outputs the boundary and quarter hits; the controller owns the state, `io_clk_o` and the update logic.

## Test plan
- Targets half=3, quarter=1, idle_high=0, enable for 40 cycles → `io_clk_o` period 8; half strobe at count 3, quarter at count 1; rising edge first at cycle 5 after enable.
- Drop enable while `io_clk_o`=1 mid-half → exactly one more half strobe, then low and `clock_active_o`=0; drop while low → no further half strobe.
- `rate_update_i` with half=7 at count 1 → current half period still 4 cycles, next 8; update on the boundary cycle → next half period already 8.
- idle_high=1, half=0 → `io_clk_o` idles high, toggles every cycle, half strobe continuous, no quarter strobe.
- `CLKS_ALOT_BURST_EN`, burst_len=3, half=2 → exactly 3 io cycles, `burst_done_o` one pulse, returns to IDLE at idle level.
- Assert reset mid-RUN → all outputs 0 immediately; re-enable restarts a clean first half period.

Source files
------------

// File: rtl/common_p.sv
// Shared clock/reset bundle used by the clks_alot blocks.
package common_p;

  typedef struct packed {
    logic clk;
    logic rst;
  } clk_dom;

endpackage

// File: rtl/rate_generation_pkg.sv
// Types and defaults for the clks_alot rate generator (package clks_alot_p).
// Optional burst mode is selected with CLKS_ALOT_BURST_EN in rate_generation.
package clks_alot_p;

  localparam int RATE_COUNTER_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rate_gen_state_e;

  typedef struct packed {
    logic [RATE_COUNTER_WIDTH_DEFAULT-1:0] half_target;
    logic [RATE_COUNTER_WIDTH_DEFAULT-1:0] quarter_target;
  } rate_cfg_s;

endpackage

// File: rtl/rate_generation_half_period_counter.sv
// Half-period counter: counts 0..half_target and registers the boundary,
// half-period and quarter-point hits so they line up with the count value.
module half_period_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         active_next,
  input  logic         mask_next,
  input  logic [W-1:0] half_target_next,
  input  logic [W-1:0] quarter_target_next,
  output logic         boundary,
  output logic         half_strobe,
  output logic         quarter_strobe
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;
  logic         boundary_next;
  logic         quarter_next;

  // Hits are evaluated on the next count so the registered flags match count_reg.
  always_comb begin
    count_next    = (hold || boundary) ? '0 : count_reg + W'(1);
    boundary_next = active_next && (count_next == half_target_next);
    quarter_next  = active_next && (count_next == quarter_target_next) &&
                    (quarter_target_next < half_target_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg      <= '0;
      boundary       <= 1'b0;
      half_strobe    <= 1'b0;
      quarter_strobe <= 1'b0;
    end else begin
      count_reg      <= count_next;
      boundary       <= boundary_next;
      half_strobe    <= boundary_next && !mask_next;
      quarter_strobe <= quarter_next;
    end
  end

endmodule

// File: rtl/rate_generation.sv
// io clock generator: IDLE/RUN/DRAIN controller around a half-period counter.
// Define CLKS_ALOT_BURST_EN to add the burst_len_i / burst_done_o burst mode.
module rate_generation
  import clks_alot_p::*;
#(
  parameter int COUNTER_WIDTH = RATE_COUNTER_WIDTH_DEFAULT
) (
  input  common_p::clk_dom           sys_dom_i,
  input  logic                       clock_enable_i,
  input  logic                       idle_high_i,
  input  logic [COUNTER_WIDTH-1:0]   half_rate_target_i,
  input  logic [COUNTER_WIDTH-1:0]   quarter_rate_target_i,
  input  logic                       rate_update_i,
`ifdef CLKS_ALOT_BURST_EN
  input  logic [15:0]                burst_len_i,
  output logic                       burst_done_o,
`endif
  output logic                       clock_active_o,
  output logic                       io_clk_o,
  output logic                       half_rate_elapsed_o,
  output logic                       quarter_rate_elapsed_o
);

  logic clk;
  logic rst;
  assign clk = sys_dom_i.clk;
  assign rst = sys_dom_i.rst;

  rate_gen_state_e          state_reg, state_next;
  logic                     io_clk_reg, io_clk_next;
  logic                     idle_lvl_reg, idle_lvl_next;
  logic                     active_reg;
  logic [COUNTER_WIDTH-1:0] half_act_reg, half_act_next;
  logic [COUNTER_WIDTH-1:0] quarter_act_reg, quarter_act_next;
  logic [COUNTER_WIDTH-1:0] half_pend_reg, half_pend_next;
  logic [COUNTER_WIDTH-1:0] quarter_pend_reg, quarter_pend_next;
  logic                     boundary;
  logic                     load_cfg;
  logic                     hold;
  logic                     active_next;
  logic                     mask_next;
`ifdef CLKS_ALOT_BURST_EN
  logic [15:0]              burst_left_reg, burst_left_next;
  logic                     burst_done_reg, burst_done_next;
`endif

  always_comb begin
    state_next    = state_reg;
    io_clk_next   = io_clk_reg;
    idle_lvl_next = idle_lvl_reg;
`ifdef CLKS_ALOT_BURST_EN
    burst_left_next = burst_left_reg;
    burst_done_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        idle_lvl_next = idle_high_i;
        io_clk_next   = idle_high_i;
        if (clock_enable_i) begin
          state_next = RUN;
`ifdef CLKS_ALOT_BURST_EN
          burst_left_next = burst_len_i;
`endif
        end
      end
      RUN: begin
        if (boundary) io_clk_next = ~io_clk_reg;
        if (!clock_enable_i) state_next = DRAIN;
`ifdef CLKS_ALOT_BURST_EN
        // A toggle back to the idle level completes one io cycle.
        if (boundary && (burst_left_reg != 16'd0) && (io_clk_reg != idle_lvl_reg)) begin
          burst_left_next = burst_left_reg - 16'd1;
          if (burst_left_reg == 16'd1) begin
            state_next      = IDLE;
            burst_done_next = 1'b1;
          end
        end
`endif
      end
      DRAIN: begin
        state_next = clock_enable_i ? RUN : DRAIN;
        if (boundary) begin
          // Only toggle if that lands on the idle level; otherwise stop where we are.
          if (io_clk_reg != idle_lvl_reg) io_clk_next = ~io_clk_reg;
          if (!clock_enable_i) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    active_next = (state_next != IDLE);
    hold        = (state_reg == IDLE) || (state_next == IDLE);
    mask_next   = (state_next == DRAIN) && (io_clk_next == idle_lvl_next);

    // Targets take effect in IDLE or at a boundary; a same-cycle update bypasses pending.
    load_cfg          = (state_reg == IDLE) || boundary;
    half_pend_next    = rate_update_i ? half_rate_target_i : half_pend_reg;
    quarter_pend_next = rate_update_i ? quarter_rate_target_i : quarter_pend_reg;
    half_act_next     = load_cfg ? half_pend_next : half_act_reg;
    quarter_act_next  = load_cfg ? quarter_pend_next : quarter_act_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      io_clk_reg       <= 1'b0;
      idle_lvl_reg     <= 1'b0;
      active_reg       <= 1'b0;
      half_act_reg     <= '0;
      quarter_act_reg  <= '0;
      half_pend_reg    <= '0;
      quarter_pend_reg <= '0;
    end else begin
      state_reg        <= state_next;
      io_clk_reg       <= io_clk_next;
      idle_lvl_reg     <= idle_lvl_next;
      active_reg       <= active_next;
      half_act_reg     <= half_act_next;
      quarter_act_reg  <= quarter_act_next;
      half_pend_reg    <= half_pend_next;
      quarter_pend_reg <= quarter_pend_next;
    end
  end

`ifdef CLKS_ALOT_BURST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_left_reg <= 16'd0;
      burst_done_reg <= 1'b0;
    end else begin
      burst_left_reg <= burst_left_next;
      burst_done_reg <= burst_done_next;
    end
  end

  assign burst_done_o = burst_done_reg;
`endif

  half_period_counter #(
    .W (COUNTER_WIDTH)
  ) u_counter (
    .clk                 (clk),
    .rst                 (rst),
    .hold                (hold),
    .active_next         (active_next),
    .mask_next           (mask_next),
    .half_target_next    (half_act_next),
    .quarter_target_next (quarter_act_next),
    .boundary            (boundary),
    .half_strobe         (half_rate_elapsed_o),
    .quarter_strobe      (quarter_rate_elapsed_o)
  );

  assign clock_active_o = active_reg;
  assign io_clk_o       = io_clk_reg;

endmodule

// File: tb/tb_rate_generation.sv
// Self-checking bench for rate_generation: directed and random scenarios
// compared cycle by cycle against a half-period schedule model.
module tb_rate_generation;

  localparam int MAXN = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  common_p::clk_dom sys_dom;
  assign sys_dom.clk = clk;
  assign sys_dom.rst = rst;

  logic        clock_enable   = 1'b0;
  logic        idle_high      = 1'b0;
  logic [15:0] half_target    = 16'd0;
  logic [15:0] quarter_target = 16'd0;
  logic        rate_update    = 1'b0;
  logic        clock_active;
  logic        io_clk;
  logic        half_elapsed;
  logic        quarter_elapsed;
`ifdef CLKS_ALOT_BURST_EN
  logic [15:0] burst_len = 16'd0;
  logic        burst_done;
  logic        exp_done [MAXN];
`endif

  logic exp_io   [MAXN];
  logic exp_half [MAXN];
  logic exp_q    [MAXN];
  logic exp_act  [MAXN];
  int   stop_k;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rate_generation dut (
    .sys_dom_i              (sys_dom),
    .clock_enable_i         (clock_enable),
    .idle_high_i            (idle_high),
    .half_rate_target_i     (half_target),
    .quarter_rate_target_i  (quarter_target),
    .rate_update_i          (rate_update),
`ifdef CLKS_ALOT_BURST_EN
    .burst_len_i            (burst_len),
    .burst_done_o           (burst_done),
`endif
    .clock_active_o         (clock_active),
    .io_clk_o               (io_clk),
    .half_rate_elapsed_o    (half_elapsed),
    .quarter_rate_elapsed_o (quarter_elapsed)
  );

  task automatic check(input string tag, input int k, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s k=%0d got=%b exp=%b", tag, k, got, exp);
    end
  endtask

  // Builds the expected trace as a sequence of half periods: period j lasts h+1
  // cycles at level idle^j; an update applies to periods starting after it.
  function automatic void build_expect(input logic idle, input int h0, input int q0,
                                       input int ku, input int h1, input int q1,
                                       input int k_off, input int burst, input int n);
    int   s;
    int   j;
    int   end_b;
    int   h;
    int   q;
    int   b;
    logic lvl;
    s = 0; j = 0; end_b = -1; stop_k = -1;
    for (int k = 0; k < MAXN; k++) begin
      exp_io[k] = idle; exp_half[k] = 1'b0; exp_q[k] = 1'b0; exp_act[k] = 1'b0;
`ifdef CLKS_ALOT_BURST_EN
      exp_done[k] = 1'b0;
`endif
    end
    while (end_b < 0 && s < n) begin
      h   = (ku >= 0 && ku < s) ? h1 : h0;
      q   = (ku >= 0 && ku < s) ? q1 : q0;
      lvl = idle ^ j[0];
      b   = s + h;
      for (int k = s; k <= b && k < MAXN; k++) begin
        exp_io[k]   = lvl;
        exp_act[k]  = 1'b1;
        exp_half[k] = (k == b);
        exp_q[k]    = ((k - s) == q) && (q < h);
      end
      if (k_off >= 0 && k_off < b) begin
        end_b = b;
        if (lvl == idle && b < MAXN) exp_half[b] = 1'b0;
      end else if (burst > 0 && (j % 2) == 1 && (j + 1) / 2 == burst) begin
        end_b  = b;
        stop_k = b + 1;
`ifdef CLKS_ALOT_BURST_EN
        if (b + 1 < MAXN) exp_done[b + 1] = 1'b1;
`endif
      end
      s = b + 1;
      j++;
    end
  endfunction

  task automatic run_scenario(input string name, input logic idle, input int h0, input int q0,
                              input int ku, input int h1, input int q1,
                              input int k_off, input int burst, input int n);
    int f0;
    f0 = failures;
    build_expect(idle, h0, q0, ku, h1, q1, k_off, burst, n);
    @(negedge clk);
    idle_high      = idle;
    half_target    = 16'(h0);
    quarter_target = 16'(q0);
    rate_update    = 1'b1;
    clock_enable   = 1'b0;
`ifdef CLKS_ALOT_BURST_EN
    burst_len = 16'(burst);
`endif
    @(negedge clk);
    rate_update = 1'b0;
    @(negedge clk);
    check({name, "_idle_io"}, -1, io_clk, idle);
    check({name, "_idle_active"}, -1, clock_active, 1'b0);
    clock_enable = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check({name, "_io"}, k, io_clk, exp_io[k]);
      check({name, "_half"}, k, half_elapsed, exp_half[k]);
      check({name, "_quarter"}, k, quarter_elapsed, exp_q[k]);
      check({name, "_active"}, k, clock_active, exp_act[k]);
`ifdef CLKS_ALOT_BURST_EN
      check({name, "_done"}, k, burst_done, exp_done[k]);
`endif
      rate_update = (k == ku);
      if (k == ku) begin
        half_target    = 16'(h1);
        quarter_target = 16'(q1);
      end
      clock_enable = !((k_off >= 0 && k >= k_off) || (stop_k >= 0 && k >= stop_k));
    end
    rate_update  = 1'b0;
    clock_enable = 1'b0;
    for (int w = 0; w < 64 && clock_active == 1'b1; w++) @(negedge clk);
    check({name, "_stop_timeout"}, n, clock_active, 1'b0);
    $display("scenario %s idle=%0b h0=%0d q0=%0d ku=%0d h1=%0d q1=%0d off=%0d burst=%0d new_failures=%0d",
             name, idle, h0, q0, ku, h1, q1, k_off, burst, failures - f0);
  endtask

  initial begin
    #12;
    check("reset_io", 0, io_clk, 1'b0);
    check("reset_active", 0, clock_active, 1'b0);
    check("reset_half", 0, half_elapsed, 1'b0);
    check("reset_quarter", 0, quarter_elapsed, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("release_half", 0, half_elapsed, 1'b0);
    check("release_active", 0, clock_active, 1'b0);

    run_scenario("basic",      1'b0, 3, 1, -1, 0, 0, -1, 0, 40);
    run_scenario("drain_high", 1'b0, 3, 1, -1, 0, 0,  5, 0, 20);
    run_scenario("drain_low",  1'b0, 3, 1, -1, 0, 0,  9, 0, 24);
    run_scenario("upd_mid",    1'b0, 3, 1,  1, 7, 2, -1, 0, 40);
    run_scenario("upd_bnd",    1'b0, 3, 1,  3, 7, 2, -1, 0, 40);
    run_scenario("fast_hi",    1'b1, 0, 0, -1, 0, 0,  8, 0, 16);
    run_scenario("q_eq_half",  1'b1, 2, 2, -1, 0, 0, 10, 0, 20);

    for (int r = 0; r < 8; r++) begin
      int h0, q0, ku, h1, q1, koff;
      h0   = int'($urandom_range(0, 6));
      q0   = int'($urandom_range(0, 7));
      ku   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1;
      h1   = int'($urandom_range(0, 6));
      q1   = int'($urandom_range(0, 7));
      koff = ($urandom_range(0, 2) != 0) ? int'($urandom_range(0, 30)) : -1;
      run_scenario("rand", 1'($urandom_range(0, 1)), h0, q0, ku, h1, q1, koff, 0, 56);
    end

`ifdef CLKS_ALOT_BURST_EN
    run_scenario("burst", 1'b0, 2, 0, -1, 0, 0, -1, 3, 30);
`endif

    // Reset asserted mid-RUN, away from a clock edge.
    @(negedge clk);
    idle_high = 1'b0; half_target = 16'd3; quarter_target = 16'd1; rate_update = 1'b1;
    @(negedge clk);
    rate_update = 1'b0; clock_enable = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_io", 0, io_clk, 1'b0);
    check("rst_mid_active", 0, clock_active, 1'b0);
    check("rst_mid_half", 0, half_elapsed, 1'b0);
    check("rst_mid_quarter", 0, quarter_elapsed, 1'b0);
    clock_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_half", 0, half_elapsed, 1'b0);
    check("rst_rel_active", 0, clock_active, 1'b0);
    check("rst_rel_io", 0, io_clk, 1'b0);
    run_scenario("restart", 1'b0, 3, 1, -1, 0, 0, 12, 0, 24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
